// File: rtl/mmio_mbox_pkg.sv
// mmio_mbox_pkg: shared definitions for the MMIO mailbox slot core.
// Holds the word register indices, the STATUS/CTRL bit positions and the
// packed STATUS layout used by mmio_mbox_core.
package mmio_mbox_pkg;

  // Word register indices
  localparam logic [4:0] REG_RX_DATA = 5'd0;
  localparam logic [4:0] REG_STATUS  = 5'd1;
  localparam logic [4:0] REG_RX_POP  = 5'd2;
  localparam logic [4:0] REG_TX_DATA = 5'd3;
  localparam logic [4:0] REG_CTRL    = 5'd4;

  // STATUS bit positions
  localparam int unsigned ST_RX_EMPTY = 0;
  localparam int unsigned ST_RX_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_TX_FULL  = 3;
  localparam int unsigned ST_RX_UNF   = 4;
  localparam int unsigned ST_TX_OVF   = 5;
  localparam int unsigned ST_RX_CNT   = 8;
  localparam int unsigned ST_TX_CNT   = 16;

  // CTRL bit positions
  localparam int unsigned CTRL_FLUSH_RX  = 0;
  localparam int unsigned CTRL_FLUSH_TX  = 1;
  localparam int unsigned CTRL_CLR_STICK = 2;
  localparam int unsigned CTRL_THR_LSB   = 8;

  // STATUS word, MSB first
  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] tx_count;
    logic [7:0] rx_count;
    logic [1:0] rsvd_lo;
    logic       tx_ovf;
    logic       rx_unf;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
  } status_t;

endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: synchronous FIFO of 2**DEPTH_LOG2 entries of DW bits.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write
// side; pop_i read side; flush_i empties the FIFO and overrides push/pop;
// full_o/empty_o/count_o occupancy; head_o oldest entry (0 when empty).
// Push while full and pop while empty are ignored.
module mbox_fifo #(
  parameter int unsigned DW         = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [DW-1:0]       data_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic [DW-1:0]       head_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PtrOne = 1;
  localparam logic [DEPTH_LOG2:0]   CntOne = 1;
  localparam logic [DEPTH_LOG2:0]   CntFull = (DEPTH_LOG2 + 1)'(Depth);

  logic [DW-1:0]         mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PtrOne;
      if (pop_ok)  rptr_d = rptr_q + PtrOne;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; head_o masks stale entries while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/mmio_mbox_core.sv
// mmio_mbox_core: MMIO mailbox slot responder.
// CPU side: cs/write/read/addr/wr_data/rd_data word registers.
// RX stream s_valid/s_data/s_ready (hardware to CPU), TX stream
// m_valid/m_data/m_ready (CPU to hardware), irq RX threshold level.
// Optional feature macro MMIO_MBOX_IRQ_EN: registered threshold irq; when
// undefined irq is 0, no threshold register exists and CTRL reads 0.
module mmio_mbox_core
  import mmio_mbox_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          irq
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0] rx_count, tx_count;
  logic [DW-1:0] rx_head;
  logic          wr_en, ctrl_wr, rx_pop_req, tx_push_req;
  logic          rx_flush, tx_flush, stick_clr;
  logic          rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;
  logic [31:0]   ctrl_rd;
  status_t       status;
  logic          unused_wdata;

  assign unused_wdata = ^wr_data;

  assign wr_en       = cs & write;
  assign rx_pop_req  = wr_en & (addr == REG_RX_POP);
  assign tx_push_req = wr_en & (addr == REG_TX_DATA);
  assign ctrl_wr     = wr_en & (addr == REG_CTRL);
  assign rx_flush    = ctrl_wr & wr_data[CTRL_FLUSH_RX];
  assign tx_flush    = ctrl_wr & wr_data[CTRL_FLUSH_TX];
  assign stick_clr   = ctrl_wr & wr_data[CTRL_CLR_STICK];

  // No bypass: readiness depends only on registered occupancy.
  assign s_ready = ~rx_full;
  assign m_valid = ~tx_empty;

  mbox_fifo #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (s_valid & s_ready),
    .data_i  (s_data),
    .pop_i   (rx_pop_req),
    .flush_i (rx_flush),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count),
    .head_o  (rx_head)
  );

  mbox_fifo #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (tx_push_req),
    .data_i  (wr_data[DW-1:0]),
    .pop_i   (m_valid & m_ready),
    .flush_i (tx_flush),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (m_data)
  );

  // Sticky flags: a set in the same cycle as a clear wins.
  assign rx_unf_d = (rx_pop_req & rx_empty) | (rx_unf_q & ~stick_clr);
  assign tx_ovf_d = (tx_push_req & tx_full) | (tx_ovf_q & ~stick_clr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_unf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      rx_unf_q <= rx_unf_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

`ifdef MMIO_MBOX_IRQ_EN
  logic [7:0] thr_q, thr_d;
  logic       irq_q, irq_d;

  assign thr_d = ctrl_wr ? wr_data[CTRL_THR_LSB +: 8] : thr_q;
  assign irq_d = (thr_q != 8'd0) && (8'(rx_count) >= thr_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thr_q <= 8'd0;
      irq_q <= 1'b0;
    end else begin
      thr_q <= thr_d;
      irq_q <= irq_d;
    end
  end

  assign irq     = irq_q;
  assign ctrl_rd = {16'd0, thr_q, 8'd0};
`else
  assign irq     = 1'b0;
  assign ctrl_rd = 32'd0;
`endif

  always_comb begin
    status          = '0;
    status.rx_empty = rx_empty;
    status.rx_full  = rx_full;
    status.tx_empty = tx_empty;
    status.tx_full  = tx_full;
    status.rx_unf   = rx_unf_q;
    status.tx_ovf   = tx_ovf_q;
    status.rx_count = 8'(rx_count);
    status.tx_count = 8'(tx_count);
  end

  // Read data is driven only for a selected read and held at 0 in reset.
  always_comb begin
    rd_data = 32'd0;
    if (cs && read && resetn) begin
      case (addr)
        REG_RX_DATA: rd_data = 32'(rx_head);
        REG_STATUS:  rd_data = status;
        REG_CTRL:    rd_data = ctrl_rd;
        default:     rd_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_mbox_core.sv
// tb_mmio_mbox_core: directed bench for mmio_mbox_core with a queue-based
// model of both mailboxes checked on every falling clock edge, plus
// hand-computed register expectations along the directed sequence.
module tb_mmio_mbox_core;

  localparam int unsigned DW    = 32;
  localparam int unsigned DL    = 4;
  localparam int          DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cs, write, read;
  logic [4:0]    addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_mbox_core #(.DW(DW), .DEPTH_LOG2(DL)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .cs      (cs),
    .write   (write),
    .read    (read),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .irq     (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] rx_q[$];
  logic [31:0] tx_q[$];
  bit          m_unf, m_ovf, m_irq;
  logic [7:0]  m_thr;

  always @(posedge clk or negedge resetn) begin : model
    int rxn, txn;
    bit wr, ctrl;
    if (!resetn) begin
      rx_q.delete();
      tx_q.delete();
      m_unf = 0;
      m_ovf = 0;
      m_irq = 0;
      m_thr = 8'd0;
    end else begin
      rxn  = rx_q.size();
      txn  = tx_q.size();
      wr   = cs && write;
      ctrl = wr && (addr == 5'd4);
`ifdef MMIO_MBOX_IRQ_EN
      m_irq = (m_thr != 0) && (rxn >= int'(m_thr));
      if (ctrl) m_thr = wr_data[15:8];
`endif
      if (ctrl && wr_data[2]) begin
        m_unf = 0;
        m_ovf = 0;
      end
      if (wr && addr == 5'd2 && rxn == 0) m_unf = 1;
      if (wr && addr == 5'd3 && txn == DEPTH) m_ovf = 1;
      if (ctrl && wr_data[0]) rx_q.delete();
      else begin
        if (wr && addr == 5'd2 && rxn > 0) void'(rx_q.pop_front());
        if (s_valid && rxn < DEPTH) rx_q.push_back(s_data);
      end
      if (ctrl && wr_data[1]) tx_q.delete();
      else begin
        if (m_ready && txn > 0) void'(tx_q.pop_front());
        if (wr && addr == 5'd3 && txn < DEPTH) tx_q.push_back(wr_data);
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    int rxn = rx_q.size();
    int txn = tx_q.size();
    logic [31:0] r = 32'd0;
    if (a == 5'd0 && rxn > 0) r = rx_q[0];
    if (a == 5'd1)
      r = {8'h00, 8'(txn), 8'(rxn), 2'b00, m_ovf, m_unf,
           txn == DEPTH, txn == 0, rxn == DEPTH, rxn == 0};
    if (a == 5'd4) r = {16'd0, m_thr, 8'd0};
    return r;
  endfunction

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic [31:0] exp_m;
    exp_m = 32'd0;
    if (tx_q.size() > 0) exp_m = tx_q[0];
    chk("s_ready", 32'(s_ready), 32'(rx_q.size() < DEPTH));
    chk("m_valid", 32'(m_valid), 32'(tx_q.size() > 0));
    chk("m_data", m_data, exp_m);
    chk("irq", 32'(irq), 32'(m_irq));
    if (cs && read) chk("rd_data", rd_data, resetn ? model_rd(addr) : 32'd0);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1; write = 1; read = 0; addr = a; wr_data = d;
    step();
    cs = 0; write = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    cs = 1; read = 1; write = 0; addr = a;
    @(negedge clk);
    chk(name, rd_data, exp);
    step();
    cs = 0; read = 0;
  endtask

  initial begin
    resetn = 0; cs = 1; read = 1; write = 0; addr = 5'd1; wr_data = 0;
    s_valid = 0; s_data = 0; m_ready = 0;
    @(negedge clk);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset s_ready", 32'(s_ready), 32'd1);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_data", m_data, 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    step();
    resetn = 1; cs = 0; read = 0;
    step();

    // 1. status after reset
    rd(5'd1, 32'h0000_0005, "status after reset");

    // 2. three pushes, read and pop
    s_valid = 1;
    s_data = 32'hA1; step();
    s_data = 32'hB2; step();
    s_data = 32'hC3; step();
    s_valid = 0;
    rd(5'd0, 32'hA1, "rx head A1");
    wr(5'd2, 32'd0);
    rd(5'd0, 32'hB2, "rx head B2");
    rd(5'd1, 32'h0000_0204, "status rx_count 2");
    wr(5'd4, 32'd1);

    // 3. fill RX, pop while the 17th word is offered
    s_valid = 1;
    for (int i = 0; i < 16; i++) begin
      s_data = 32'h10 + 32'(i);
      step();
    end
    s_data = 32'h20;
    rd(5'd1, 32'h0000_1006, "status rx full");
    chk("s_ready when full", 32'(s_ready), 32'd0);
    cs = 1; write = 1; addr = 5'd2;
    chk("s_ready during pop", 32'(s_ready), 32'd0);
    step();
    cs = 0; write = 0;
    chk("s_ready after pop", 32'(s_ready), 32'd1);
    step();
    s_valid = 0;
    rd(5'd1, 32'h0000_1006, "status refilled");
    rd(5'd0, 32'h11, "rx head after pop");
    wr(5'd4, 32'd1);

    // 4. TX overflow and drain
    for (int i = 0; i < 17; i++) wr(5'd3, 32'h100 + 32'(i));
    rd(5'd1, 32'h0010_0029, "status tx full ovf");
    m_ready = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tx drain order", m_data, 32'h100 + 32'(i));
      step();
    end
    m_ready = 0;
    chk("m_valid after drain", 32'(m_valid), 32'd0);
    rd(5'd1, 32'h0000_0025, "status ovf sticky");
    wr(5'd4, 32'd4);
    rd(5'd1, 32'h0000_0005, "status ovf cleared");

    // 5. underflow, flush racing a push
    wr(5'd2, 32'd0);
    rd(5'd1, 32'h0000_0015, "status rx_unf");
    s_valid = 1; s_data = 32'h55;
    wr(5'd4, 32'd1);
    s_valid = 0;
    rd(5'd1, 32'h0000_0015, "status flush wins");
    wr(5'd4, 32'd4);

    // 6. threshold interrupt
`ifdef MMIO_MBOX_IRQ_EN
    wr(5'd4, 32'h0000_0300);
    rd(5'd4, 32'h0000_0300, "ctrl threshold");
`endif
    s_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'h30 + 32'(i);
      step();
    end
    s_valid = 0;
    chk("irq right after 3rd push", 32'(irq), 32'd0);
    step();
`ifdef MMIO_MBOX_IRQ_EN
    chk("irq asserted", 32'(irq), 32'd1);
    wr(5'd2, 32'd0);
    chk("irq held on pop edge", 32'(irq), 32'd1);
    step();
    chk("irq released", 32'(irq), 32'd0);
`else
    chk("irq tied low", 32'(irq), 32'd0);
    rd(5'd4, 32'd0, "ctrl reads zero");
`endif
    wr(5'd4, 32'd1);

    // async reset mid-transfer
    wr(5'd3, 32'hDEAD);
    wr(5'd3, 32'hBEEF);
    chk("m_valid before reset", 32'(m_valid), 32'd1);
    s_valid = 1; s_data = 32'h77;
    #2 resetn = 0;
    #1;
    chk("async reset m_valid", 32'(m_valid), 32'd0);
    chk("async reset m_data", m_data, 32'd0);
    chk("async reset s_ready", 32'(s_ready), 32'd1);
    s_valid = 0;
    step();
    resetn = 1;
    step();
    rd(5'd1, 32'h0000_0005, "status after async reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_mbox_core.md
Name: mmio_mbox_core

Overview:
- Memory-mapped mailbox slot core. It is the responder on the MMIO slot bus driven by the bridge/mmio_sys decode.
- CPU side: word-register reads and writes.
- Hardware side: one ingress stream (RX FIFO, hardware to CPU) and one egress stream (TX FIFO, CPU to hardware), both valid/ready.
- Plugs into a free mmio_sys slot and decouples firmware from free-running hardware producers and consumers.

Parameters:
DW, 32, stream and FIFO data width (1..32; CPU sees it zero-extended to 32 bits).
DEPTH_LOG2, 4, log2 of each FIFO depth (legal range 1..7, so the count fits 8 bits).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cs  in  1  slot select
write  in  1  write strobe, qualified by cs
read  in  1  read strobe, qualified by cs
addr  in  5  word register index
wr_data  in  32  write data
rd_data  out  32  read data, combinational from registered state
s_valid  in  1  RX ingress valid
s_data  in  DW  RX ingress data
s_ready  out  1  RX ingress ready
m_valid  out  1  TX egress valid
m_data  out  DW  TX egress data
m_ready  in  1  TX egress ready
irq  out  1  RX threshold interrupt, level

Behaviour:
- Reset state: both FIFOs empty, counts 0, sticky flags 0, threshold 0. During reset: s_ready=1, m_valid=0, m_data=0, irq=0, rd_data=0.
- Register map, read side (addr):
  - 0 RX_DATA: RX head zero-extended; 0 if RX is empty.
  - 1 STATUS: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_unf, [5] tx_ovf, [15:8] rx_count, [23:16] tx_count, rest 0.
  - 4 CTRL: [15:8] threshold.
  - Other indices read 0. Reads have no side effects.
- Register map, write side (cs&write):
  - 2 RX_POP: any data; pops the RX head.
  - 3 TX_DATA: pushes wr_data[DW-1:0].
  - 4 CTRL: [0] flush RX, [1] flush TX, [2] clear rx_unf and tx_ovf, [15:8] threshold (registered).
  - Writes to 0, 1 and 5..31 are ignored.
- RX FIFO:
  - s_ready = !rx_full. Push occurs when s_valid&s_ready.
  - No combinational bypass: a full FIFO stays not-ready in a cycle that also pops.
  - Data is visible on RX_DATA the cycle after the push.
- TX FIFO:
  - m_valid = !tx_empty, m_data = head. Pop occurs when m_valid&m_ready.
  - A push lands the cycle after the write.
- Same-cycle push and pop on a non-empty FIFO: count unchanged, both take effect.
- RX_POP when RX is empty: no pop, rx_unf<=1 (sticky).
- TX_DATA when tx_full (judged on pre-cycle state, even if a hardware pop occurs in the same cycle): data dropped, tx_ovf<=1 (sticky).
- Sticky flag set and CTRL[2] clear in the same cycle: set wins.
- Flush in the same cycle as a push or pop on that FIFO: flush wins, and the FIFO is empty next cycle. Flush does not alter sticky flags.
- Pointers wrap modulo 2^DEPTH_LOG2. Count ranges 0..2^DEPTH_LOG2, and full is count == depth.
- Asynchronous reset assertion mid-transfer immediately clears all state. In-flight data is lost and m_valid drops asynchronously.

Optional Feature:
- MMIO_MBOX_IRQ_EN defined: irq is registered and asserts the cycle after rx_count >= threshold with threshold != 0. It deasserts the cycle after the condition fails.
- MMIO_MBOX_IRQ_EN undefined: irq is tied 0, the threshold register is not implemented, and CTRL reads 0.

Decomposition:
- Package mmio_mbox_pkg: register index localparams (REG_RX_DATA=0, REG_STATUS=1, REG_RX_POP=2, REG_TX_DATA=3, REG_CTRL=4), STATUS and CTRL bit-position localparams, and a status struct typedef.
- Sub-module mbox_fifo: synchronous FIFO, parameters DW and DEPTH_LOG2, with push, pop, flush, full, empty, count and head outputs. It is instantiated twice.

Test Plan:
1. Reset, then read STATUS -> 32'h0000_0005 (rx_empty, tx_empty); s_ready=1, m_valid=0.
2. Drive s_data 0xA1, 0xB2, 0xC3 on consecutive cycles.
   - Read RX_DATA -> 0xA1; write RX_POP; read RX_DATA -> 0xB2; STATUS[15:8] = 2.
3. Fill RX with 16 words while holding s_valid.
   - s_ready=0 after the 16th; rx_full=1; a pop in the same cycle as the 17th s_valid keeps s_ready low that cycle; the 17th word enters the cycle after.
4. m_ready=0, write TX_DATA 17 times.
   - tx_full=1, tx_ovf=1, tx_count=16; then m_ready=1 drains 16 words in order with the first word first; CTRL[2] clears tx_ovf.
5. Write RX_POP on empty -> rx_unf=1; flush RX while s_valid pushes in the same cycle -> next cycle rx_count=0.
6. With MMIO_MBOX_IRQ_EN, CTRL threshold=3: push 3 words -> irq=1 one cycle after the third push; pop one -> irq=0 next cycle. Without the macro, irq stays 0.
